btoex3: RTL and testbench
=========================

// Module: btoex3
// PURPOSE
//  - Binary-to-excess-3 code converter: e = b + 3, computed without overflow.
//  - Registered (1-cycle) leaf block with a valid strobe.
//  - Feeds excess-3 displays and self-complementing arithmetic stages downstream of 4-bit binary/BCD sources.
// PARAMETERS
//  - IN_W    4        input code width in bits
//  - OFFSET  3        excess offset added to the input
//  - OUT_W   IN_W+1   output width; holds the maximum value 2^IN_W-1+OFFSET without overflow
// PORTS
//  - clk        in   1      single clock; all state updates on its rising edge
//  - rst_n      in   1      reset, asynchronous, active-low
//  - in_valid   in   1      b is valid this cycle
//  - b          in   IN_W   unsigned binary input code
//  - out_valid  out  1      e holds a freshly converted value
//  - e          out  OUT_W  excess-3 code of the last accepted b
//  - bcd_err    out  1      present only with BTOEX3_BCD_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous assert): e=0, out_valid=0, bcd_err=0. Outputs stay there while rst_n is low.
//  - Reset release is synchronous: the first capture happens on the first rising clk edge with rst_n=1.
//  - Each rising clk edge with in_valid=1:
//      e <= zero-extend(b) + OFFSET, computed in OUT_W bits;
//      out_valid <= 1.
//  - Each rising clk edge with in_valid=0: out_valid <= 0; e holds its previous value.
//  - Latency is exactly 1 cycle. Throughput is 1 conversion per cycle. No backpressure.
//  - Full input range is legal: b=0 -> e=3 (5'b00011); b=15 -> e=18 (5'b10010). The MSB of e sets only for b>=13.
//  - Arithmetic is unsigned. The addition never wraps because OUT_W = IN_W+1.
//  - Reset asserted mid-stream: outputs clear immediately; the in-flight conversion is discarded.
//  - b is don't-care while in_valid=0. X on b must not propagate when in_valid=0.
// CONFIGURATION
//  - Macro BTOEX3_BCD_CHECK_EN.
//  - Defined:
//      bcd_err is registered alongside e;
//      on an accepted input, bcd_err <= (b > 9), i.e. b is not a legal BCD digit;
//      e is still converted normally;
//      bcd_err clears on reset and on any accepted b <= 9;
//      bcd_err holds when in_valid=0.
//  - Undefined: the bcd_err port does not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Package btoex3_pkg: EX3_OFFSET=3, EX3_IN_W=4, EX3_OUT_W=5, BCD_MAX=9.
//  - Sub-module btoex3_core: purely combinational adder, b -> b+OFFSET.
//  - The top level wraps btoex3_core with the valid/output registers and, when enabled, the BCD check.
// TESTING
//  - Reset: hold rst_n=0 and toggle b/in_valid -> e=0, out_valid=0 throughout.
//  - Sweep: in_valid=1, b=0..15 on consecutive cycles -> e=b+3 one cycle later (3..18), out_valid=1 every cycle.
//  - Hold: in_valid=0 after b=7 -> out_valid=0 next cycle, e stays 10.
//  - Boundary: b=12 -> e=5'b01111; b=13 -> e=5'b10000; b=15 -> e=5'b10010.
//  - Async reset: drop rst_n mid-cycle after b=5 -> e=0 and out_valid=0 immediately, before the next clk edge.
//  - With BTOEX3_BCD_CHECK_EN: b=9 -> bcd_err=0; b=10 -> bcd_err=1, e=13; b=2 -> bcd_err=0.

Source files
------------

// File: rtl/btoex3_pkg.sv
// Shared constants for the binary-to-excess-3 converter.
//   EX3_OFFSET : excess offset added to every input code
//   EX3_IN_W   : default input code width
//   EX3_OUT_W  : default output width (one bit wider than the input so the sum never wraps)
//   BCD_MAX    : largest legal BCD digit, used by the optional BCD range check
package btoex3_pkg;

    localparam int EX3_OFFSET = 3;
    localparam int EX3_IN_W   = 4;
    localparam int EX3_OUT_W  = 5;
    localparam int BCD_MAX    = 9;

endpackage : btoex3_pkg

// File: rtl/btoex3_core.sv
// Purely combinational adder: sum = zero-extend(b) + OFFSET.
// Ports:
//   b   in  IN_W   unsigned binary input code
//   sum out OUT_W  b + OFFSET, computed in OUT_W bits
// The offset is a constant, so the ripple-carry chain below collapses to a
// handful of gates per bit after constant propagation.
module btoex3_core
    import btoex3_pkg::*;
#(
    parameter int IN_W   = EX3_IN_W,
    parameter int OFFSET = EX3_OFFSET,
    parameter int OUT_W  = EX3_OUT_W
) (
    input  logic [IN_W-1:0]  b,
    output logic [OUT_W-1:0] sum
);

    localparam logic [OUT_W-1:0] K = OUT_W'(OFFSET);

    logic [OUT_W-1:0] a;
    logic [OUT_W-1:0] carry;

    assign a        = OUT_W'(b);
    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign sum[gi] = a[gi] ^ K[gi] ^ carry[gi];
            // The carry out of the top bit is always zero because OUT_W
            // leaves headroom, so it is not built.
            if (gi < OUT_W - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & K[gi]) | (carry[gi] & (a[gi] ^ K[gi]));
            end
        end
    endgenerate

endmodule : btoex3_core

// File: rtl/btoex3.sv
// Binary-to-excess-3 converter with a one-cycle registered output and valid strobe.
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset (release sampled on clk)
//   in_valid  in   1      b is valid this cycle
//   b         in   IN_W   unsigned binary input code
//   out_valid out  1      e holds a freshly converted value
//   e         out  OUT_W  excess-3 code of the last accepted b
//   bcd_err   out  1      only with BTOEX3_BCD_CHECK_EN: last accepted b was above 9
// Optional feature macro: BTOEX3_BCD_CHECK_EN adds the registered bcd_err flag.
module btoex3
    import btoex3_pkg::*;
#(
    parameter int IN_W   = EX3_IN_W,
    parameter int OFFSET = EX3_OFFSET,
    parameter int OUT_W  = IN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  b,
    output logic             out_valid,
    output logic [OUT_W-1:0] e
`ifdef BTOEX3_BCD_CHECK_EN
    ,
    output logic             bcd_err
`endif
);

    logic [OUT_W-1:0] e_next;
    logic [OUT_W-1:0] e_reg;
    logic             out_valid_reg;

    btoex3_core #(
        .IN_W   (IN_W),
        .OFFSET (OFFSET),
        .OUT_W  (OUT_W)
    ) u_core (
        .b   (b),
        .sum (e_next)
    );

    // e only loads on an accepted input, so an undriven b while in_valid is
    // low never reaches the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                e_reg <= e_next;
            end
        end
    end

    assign e         = e_reg;
    assign out_valid = out_valid_reg;

`ifdef BTOEX3_BCD_CHECK_EN
    logic bcd_err_next;
    logic bcd_err_reg;

    assign bcd_err_next = (b > IN_W'(BCD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_err_reg <= 1'b0;
        end else if (in_valid) begin
            bcd_err_reg <= bcd_err_next;
        end
    end

    assign bcd_err = bcd_err_reg;
`endif

endmodule : btoex3

// File: tb/tb_btoex3.sv
// Self-checking bench for btoex3: directed steps followed by a random phase,
// all checked against a simple arithmetic model of the converter.
module tb_btoex3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] b;
    logic       out_valid;
    logic [4:0] e;
`ifdef BTOEX3_BCD_CHECK_EN
    logic       bcd_err;
`endif

    int total;
    int bad;

    // Reference model state: what the outputs must show after the last edge.
    logic [4:0] exp_e;
    logic       exp_v;
    logic       exp_err;

    btoex3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .b         (b),
        .out_valid (out_valid),
        .e         (e)
`ifdef BTOEX3_BCD_CHECK_EN
        ,
        .bcd_err   (bcd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".e"}, 32'(e), 32'(exp_e));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_v));
`ifdef BTOEX3_BCD_CHECK_EN
        check({tag, ".bcd_err"}, 32'(bcd_err), 32'(exp_err));
`endif
    endtask

    task automatic model_reset();
        exp_e   = 5'd0;
        exp_v   = 1'b0;
        exp_err = 1'b0;
    endtask

    // Drive one cycle (called at a negedge), update the model at the rising
    // edge, then check at the following negedge.
    task automatic cyc(input logic v, input logic [3:0] bv, input string tag);
        in_valid = v;
        b        = v ? bv : 4'bxxxx;
        @(posedge clk);
        if (rst_n) begin
            if (v) begin
                exp_e   = 5'(int'(bv) + 3);
                exp_err = (int'(bv) > 9);
            end
            exp_v = v;
        end
        @(negedge clk);
        check_all(tag);
        $display("cycle t=%0t in_valid=%0b b=%0d -> e=%0d out_valid=%0b", $time, v, bv, e, out_valid);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        b        = 4'd0;
        model_reset();

        // Reset held: inputs toggle, outputs must stay cleared.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(i * 5), "reset_hold");
        end
        rst_n = 1'b1;

        // Sweep full range back to back.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'(i), "sweep");
            check("sweep.msb", 32'(e[4]), 32'(i >= 13));
        end

        // Hold: e keeps its value while in_valid is low, even with b unknown.
        cyc(1'b1, 4'd7, "hold_load");
        cyc(1'b0, 4'd0, "hold_idle");
        check("hold.e_is_10", 32'(e), 32'd10);
        cyc(1'b0, 4'd0, "hold_idle2");

        // Boundaries around the output MSB.
        cyc(1'b1, 4'd12, "bound12");
        check("bound12.bits", 32'(e), 32'b01111);
        cyc(1'b1, 4'd13, "bound13");
        check("bound13.bits", 32'(e), 32'b10000);
        cyc(1'b1, 4'd15, "bound15");
        check("bound15.bits", 32'(e), 32'b10010);

`ifdef BTOEX3_BCD_CHECK_EN
        cyc(1'b1, 4'd9, "bcd9");
        cyc(1'b1, 4'd10, "bcd10");
        check("bcd10.e", 32'(e), 32'd13);
        cyc(1'b0, 4'd0, "bcd_hold");
        cyc(1'b1, 4'd2, "bcd2");
`endif

        // Asynchronous reset in the middle of a cycle.
        cyc(1'b1, 4'd5, "async_pre");
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_immediate");
        cyc(1'b1, 4'd9, "async_held");
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_btoex3
